// File: rtl/ap_mult_pkg.sv
// Shared types, default compressor tables and the column-index helper
// for the approximate LUT multiplier.
package ap_mult_pkg;

    localparam int LUT_W = 16;

    typedef logic [LUT_W-1:0] lut_t;

    localparam lut_t LUT_OR   = 16'hFFFE;
    localparam lut_t LUT_AND  = 16'h8000;
    localparam lut_t LUT_XOR  = 16'h6996;
    localparam lut_t LUT_ZERO = 16'h0000;

    // Column c bits ordered i = 0..c; bit k of the index is pp[c-k][k],
    // so pp[c][0] lands in the LSB. Unused upper bits stay zero.
    function automatic logic [3:0] apx_col_index(
        input logic [15:0] a,
        input logic [15:0] b,
        input int          c
    );
        logic [3:0] idx;
        idx = '0;
        for (int k = 0; k < 4; k++) begin
            if (k <= c) begin
                idx[k] = a[4'(c - k)] & b[4'(k)];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ap_mult_lut_pipe_com_lut4.sv
// Programmable 4-input approximate compressor: one table bit per pattern.
// Ports: lut (truth table), idx (input pattern), y (selected output bit).
module ap_com_lut4
    import ap_mult_pkg::*;
(
    input  lut_t       lut,
    input  logic [3:0] idx,
    output logic       y
);

    assign y = lut[idx];

endmodule

// File: rtl/ap_mult_lut_pipe.sv
// Two-stage unsigned approximate multiplier; low columns via LUTs.
// Ports: in_* operand handshake, out_* product handshake, cfg_* LUT write.
module ap_mult_lut_pipe
    import ap_mult_pkg::*;
#(
    parameter int          W        = 12,
    parameter int          APX_COLS = 4,
    parameter logic [15:0] LUT_RST  = 16'hFFFE
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    input  logic           in_exact,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_p,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [1:0]     cfg_idx,
    input  logic [15:0]    cfg_lut
);

    logic           v0;
    logic           e0;
    logic [W-1:0]   a0;
    logic [W-1:0]   b0;
    lut_t           lut_q [APX_COLS];
    logic [APX_COLS-1:0] col_bit;
    logic [2*W-1:0] p_exact;
    logic [2*W-1:0] p_apx;
    logic [2*W-1:0] p_next;
    logic           adv;
    logic           accept;
    logic           cfg_fire;

    assign adv       = !out_valid || out_ready;
    // Config wins over operands so a pending write can drain the pipe.
    assign in_ready  = adv && !cfg_valid;
    assign accept    = in_valid && in_ready;
    assign cfg_ready = !v0 && !out_valid;
    assign cfg_fire  = cfg_valid && cfg_ready;

    for (genvar c = 0; c < APX_COLS; c++) begin : g_col
        ap_com_lut4 u_lut (
            .lut (lut_q[c]),
            .idx (apx_col_index(16'(a0), 16'(b0), c)),
            .y   (col_bit[c])
        );
    end

    always_comb begin
        logic [2*W-1:0] pp;
        pp      = '0;
        p_exact = '0;
        p_apx   = '0;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                pp      = {{(2*W-1){1'b0}}, a0[i] & b0[j]};
                p_exact = p_exact + (pp << (i + j));
                if (i + j >= APX_COLS) begin
                    p_apx = p_apx + (pp << (i + j));
                end
            end
        end
        for (int c = 0; c < APX_COLS; c++) begin
            p_apx = p_apx + ({{(2*W-1){1'b0}}, col_bit[c]} << c);
        end
        p_next = e0 ? p_exact : p_apx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0 <= 1'b0;
            e0 <= 1'b0;
            a0 <= '0;
            b0 <= '0;
        end else if (adv) begin
            v0 <= accept;
            if (accept) begin
                a0 <= in_a;
                b0 <= in_b;
                e0 <= in_exact;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_p     <= '0;
        end else if (adv) begin
            out_valid <= v0;
            if (v0) begin
                out_p <= p_next;
            end
        end
    end

    // Writes only land with both stages empty, so no in-flight
    // transaction ever sees a table change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < APX_COLS; c++) begin
                lut_q[c] <= LUT_RST;
            end
        end else if (cfg_fire) begin
            for (int c = 0; c < APX_COLS; c++) begin
                if (cfg_idx == 2'(c)) begin
                    lut_q[c] <= cfg_lut;
                end
            end
        end
    end

endmodule
